// File: rtl/uart_sched_pkg.sv
// Shared types and constants for the UART transmit scheduler: FSM states,
// baud selection codes and default timing parameters.
package uart_sched_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        WAIT_DONE = 2'd2,
        GAP       = 2'd3
    } sched_state_t;

    localparam logic [2:0] BAUD_9600   = 3'd0;
    localparam logic [2:0] BAUD_19200  = 3'd1;
    localparam logic [2:0] BAUD_38400  = 3'd2;
    localparam logic [2:0] BAUD_57600  = 3'd3;
    localparam logic [2:0] BAUD_115200 = 3'd4;

    localparam int GAP_CYCLES_DEF = 16;
    localparam int TIMEOUT_DEF    = 70000;

    // Counter width that can hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request found searching
// upward from (ptr+1) with wrap. Shared by the peripheral schedulers.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             any
);

    logic found;
    int   j;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = |req;
        found   = 1'b0;
        j       = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            j = (int'(ptr) + k) % N_REQ;
            if (!found && req[IDX_W'(j)]) begin
                found             = 1'b1;
                gnt[IDX_W'(j)]    = 1'b1;
                gnt_idx           = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART byte transmitter between N_REQ producers: round-robin accept,
// one-cycle send pulse, wait for completion with watchdog, then an idle gap.
module uart_tx_scheduler
    import uart_sched_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int GAP_CYCLES = GAP_CYCLES_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF
) (
    input  logic               clk,
    input  logic               n_reset,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]   req_ready,
    input  logic [2:0]         baud_sel,
    output logic [7:0]         tx_data,
    output logic               tx_send_go,
    output logic [2:0]         tx_baud_set,
    input  logic               tx_done,
    output logic               busy,
    output logic [2:0]         grant_id,
    output logic               timeout_err
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int TMO_W = cnt_width(TIMEOUT);
    localparam int GAP_W = cnt_width(GAP_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    sched_state_t     state;
    logic [IDX_W-1:0] ptr;
    logic [TMO_W-1:0] tmo_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic [N_REQ-1:0] gnt;
    logic [IDX_W-1:0] gnt_idx;
    logic             any;

    rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_arb (
        .req     (req_valid),
        .ptr     (ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (any)
    );

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state       <= IDLE;
            ptr         <= IDX_W'(N_REQ - 1);
            req_ready   <= '0;
            tx_send_go  <= 1'b0;
            tx_data     <= '0;
            tx_baud_set <= '0;
            busy        <= 1'b0;
            grant_id    <= '0;
            timeout_err <= 1'b0;
            tmo_cnt     <= '0;
            gap_cnt     <= '0;
        end else begin
            req_ready  <= '0;
            tx_send_go <= 1'b0;
            case (state)
                IDLE: if (any) begin
                    req_ready   <= gnt;
                    tx_data     <= req_data[int'(gnt_idx)*8 +: 8];
                    tx_baud_set <= baud_sel;
                    grant_id    <= 3'(gnt_idx);
                    ptr         <= gnt_idx;
                    busy        <= 1'b1;
                    state       <= LOAD;
                end
                LOAD: begin
                    tx_send_go <= 1'b1;
                    tmo_cnt    <= '0;
                    state      <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    // A completion on the terminal count still counts as success.
                    if (tx_done || tmo_cnt == TMO_LAST) begin
                        timeout_err <= !tx_done;
                        gap_cnt     <= '0;
                        if (GAP_CYCLES == 0) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= GAP;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: table vectors, directed corner sequences and
// random traffic, all checked every cycle against a timestamp-based model.
module tb_uart_tx_scheduler;

    localparam int N   = 4;
    localparam int GAP = 16;
    localparam int TMO = 100;

    logic           clk = 1'b0;
    logic           n_reset = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0]   req_ready;
    logic [2:0]     baud_sel = '0;
    logic [7:0]     tx_data;
    logic           tx_send_go;
    logic [2:0]     tx_baud_set;
    logic           tx_done = 1'b0;
    logic           busy;
    logic [2:0]     grant_id;
    logic           timeout_err;

    always #5 clk = ~clk;

    uart_tx_scheduler #(.N_REQ(N), .GAP_CYCLES(GAP), .TIMEOUT(TMO)) dut (
        .clk         (clk),
        .n_reset     (n_reset),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .baud_sel    (baud_sel),
        .tx_data     (tx_data),
        .tx_send_go  (tx_send_go),
        .tx_baud_set (tx_baud_set),
        .tx_done     (tx_done),
        .busy        (busy),
        .grant_id    (grant_id),
        .timeout_err (timeout_err)
    );

    int checks = 0;
    int errors = 0;

    // Model: edge counter plus timestamps of the byte in flight and the
    // earliest edge at which the next accept may occur.
    int         t = 0;
    int         m_last = N - 1;
    int         m_go_at = -10;
    int         m_free_at = 0;
    bit         m_inflight = 1'b0;
    bit         m_err = 1'b0;
    logic [7:0] m_data = '0;
    logic [2:0] m_baud = '0;
    logic [2:0] m_gid = '0;

    int tx_lat = 5;
    int tx_cnt = 0;
    bit stray_en = 1'b0;

    typedef struct {
        logic [N-1:0] valid;
        logic [31:0]  data;
        logic [2:0]   baud;
        int           lat;
        int           exp_gnt;
        logic [7:0]   exp_byte;
    } vec_t;
    vec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0d actual=%0h required=%0h", name, t, act, exp);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++)
            if (v[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    task automatic model_reset();
        m_last = N - 1; m_inflight = 1'b0; m_err = 1'b0; m_free_at = 0;
        m_data = '0; m_baud = '0; m_gid = '0; m_go_at = -10;
        tx_cnt = 0; tx_done = 1'b0;
    endtask

    task automatic step();
        logic [N-1:0] exp_ready;
        int w;
        @(posedge clk); #1;
        exp_ready = '0;
        if (n_reset) begin
            t++;
            if (m_inflight) begin
                if (t > m_go_at && tx_done) begin
                    m_err = 1'b0; m_inflight = 1'b0; m_free_at = t + GAP + 1;
                end else if (t == m_go_at + TMO) begin
                    m_err = 1'b1; m_inflight = 1'b0; m_free_at = t + GAP + 1;
                end
            end else if (t >= m_free_at && |req_valid) begin
                w = rr_pick(req_valid, m_last);
                exp_ready[w] = 1'b1;
                m_data = req_data[w*8 +: 8];
                m_baud = baud_sel;
                m_gid = 3'(w);
                m_last = w;
                m_inflight = 1'b1;
                m_go_at = t + 1;
            end
        end
        chk("req_ready", req_ready, exp_ready);
        chk("tx_send_go", tx_send_go, n_reset && m_inflight && t == m_go_at);
        chk("busy", busy, m_inflight || t < m_free_at - 1);
        chk("tx_data", tx_data, m_data);
        chk("tx_baud_set", tx_baud_set, m_baud);
        chk("grant_id", grant_id, m_gid);
        chk("timeout_err", timeout_err, m_err);
        // Transmitter model: completion pulse tx_lat edges after send_go.
        tx_done = 1'b0;
        if (!n_reset) tx_cnt = 0;
        else begin
            if (tx_send_go && tx_lat != 0) tx_cnt = tx_lat;
            if (tx_cnt > 0) begin
                tx_cnt--;
                if (tx_cnt == 0) tx_done = 1'b1;
            end
            if (stray_en && $urandom_range(0, 39) == 0) tx_done = 1'b1;
        end
    endtask

    task automatic wait_ready(output int idx);
        bit got;
        idx = -1; got = 1'b0;
        for (int n = 0; n < 300 && !got; n++) begin
            step();
            if (|req_ready) begin
                got = 1'b1;
                for (int i = 0; i < N; i++) if (req_ready[i]) idx = i;
            end
        end
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 400 && busy; n++) step();
        chk("idle_reached", busy, 1'b0);
    endtask

    initial begin
        int g;
        int t_go;
        int t_acc[5];

        tbl[0] = '{4'b0001, 32'h0000_0055, 3'd4, 5, 0, 8'h55};
        tbl[1] = '{4'b1111, 32'hA3A2_A1A0, 3'd1, 3, 1, 8'hA1};
        tbl[2] = '{4'b1010, 32'h4433_2211, 3'd2, 7, 3, 8'h44};
        tbl[3] = '{4'b1010, 32'h4433_2211, 3'd3, 2, 1, 8'h22};
        tbl[4] = '{4'b0101, 32'hDDCC_BBAA, 3'd0, 9, 2, 8'hCC};
        tbl[5] = '{4'b0001, 32'h0000_00F0, 3'd4, 1, 0, 8'hF0};

        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_ready", req_ready, 0);
        chk("rst_go", tx_send_go, 1'b0);
        step(); step();
        n_reset = 1'b1;

        for (int v = 0; v < 6; v++) begin
            req_data = tbl[v].data; baud_sel = tbl[v].baud;
            tx_lat = tbl[v].lat; req_valid = tbl[v].valid;
            wait_ready(g);
            req_valid = '0;
            chk("tbl_grant", g, tbl[v].exp_gnt);
            chk("tbl_data", tx_data, tbl[v].exp_byte);
            chk("tbl_baud", tx_baud_set, tbl[v].baud);
            step();
            chk("tbl_go", tx_send_go, 1'b1);
            wait_idle();
        end

        // Watchdog: no completion ever arrives.
        tx_lat = 0; req_data = 32'h0077_0000; req_valid = 4'b0100;
        wait_ready(g);
        req_valid = '0;
        chk("tmo_grant", g, 2);
        step();
        t_go = t;
        for (int n = 0; n < 300 && !timeout_err; n++) step();
        chk("tmo_cycles", t - t_go, TMO);
        wait_idle();
        tx_lat = 4; req_data = 32'h0000_0031; req_valid = 4'b0001;
        wait_ready(g);
        req_valid = '0;
        chk("tmo_sticky", timeout_err, 1'b1);
        wait_idle();
        chk("tmo_clear", timeout_err, 1'b0);

        // Baud change mid-byte is not picked up until the next accept.
        baud_sel = 3'd0; tx_lat = 20; req_data = 32'h5A00_0000; req_valid = 4'b1000;
        wait_ready(g);
        req_valid = '0; baud_sel = 3'd2;
        for (int n = 0; n < 5; n++) step();
        chk("baud_hold", tx_baud_set, 3'd0);
        wait_idle();
        chk("baud_hold_idle", tx_baud_set, 3'd0);
        req_data = 32'h0000_0066; req_valid = 4'b0001;
        wait_ready(g);
        req_valid = '0;
        chk("baud_new", tx_baud_set, 3'd2);
        wait_idle();

        // Asynchronous reset in WAIT_DONE, then a stray completion.
        tx_lat = 0; req_data = 32'h0000_9900; req_valid = 4'b0010;
        wait_ready(g);
        req_valid = '0;
        step(); step(); step();
        #2 n_reset = 1'b0;
        #1;
        chk("rst_async_busy", busy, 1'b0);
        chk("rst_async_data", tx_data, 8'h00);
        chk("rst_async_baud", tx_baud_set, 3'd0);
        chk("rst_async_gid", grant_id, 3'd0);
        chk("rst_async_err", timeout_err, 1'b0);
        model_reset();
        step(); step();
        n_reset = 1'b1;
        tx_done = 1'b1;
        step();
        chk("stray_done", busy, 1'b0);
        step();
        chk("stray_done_late", busy, 1'b0);

        // All four held valid: strict rotation from requester 0.
        tx_lat = 10; req_data = 32'hA3A2_A1A0; req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_ready(g);
            t_acc[k] = t;
            chk("rr_order", g, k % 4);
            chk("rr_byte", tx_data, 8'hA0 + 8'(k % 4));
            if (k > 0) chk("go_spacing", t_acc[k] - t_acc[k-1], 10 + GAP + 2);
        end
        req_valid = '0;
        wait_idle();

        // Requesters 1 and 3 with pointer at 3.
        req_data = 32'hB3B2_B1B0; req_valid = 4'b1000;
        wait_ready(g);
        req_valid = '0;
        chk("p3_setup", g, 3);
        wait_idle();
        req_valid = 4'b1010;
        wait_ready(g);
        chk("p3_first", g, 1);
        wait_ready(g);
        chk("p3_second", g, 3);
        req_valid = '0;
        wait_idle();

        // Random traffic: hold-until-accepted producers, occasional drops,
        // random latency including never-completing bytes, stray completions.
        stray_en = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            step();
            for (int i = 0; i < N; i++) begin
                if (req_ready[i]) req_valid[i] = 1'b0;
                else if (!req_valid[i] && $urandom_range(0, 7) == 0) begin
                    req_data[i*8 +: 8] = 8'($urandom);
                    req_valid[i] = 1'b1;
                end else if (req_valid[i] && $urandom_range(0, 199) == 0)
                    req_valid[i] = 1'b0;
            end
            baud_sel = 3'($urandom_range(0, 4));
            tx_lat = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 30));
        end
        stray_en = 1'b0;
        req_valid = '0;
        tx_lat = 3;
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
